// File: rtl/rvfi_regfile_shadow_check.sv
// RVFI register-file shadow checker: tracks selected registers across
// retirement channels and latches the first read/write consistency error.
// Optional ORDER_GAP check enabled by RISCV_FORMAL_REGCHK_ORDER_EN.
module rvfi_regfile_shadow_check #(
    parameter int XLEN      = 32,
    parameter int NRET      = 1,
    parameter int NTRACK    = 2,
    parameter int ORDER_W   = 64,
    parameter int ZERO_INIT = 0
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic [NTRACK*5-1:0]         track_idx,
    input  logic [NRET-1:0]             rvfi_valid,
    input  logic [NRET*ORDER_W-1:0]     rvfi_order,
    input  logic [NRET-1:0]             rvfi_trap,
    input  logic [NRET*5-1:0]           rvfi_rs1_addr,
    input  logic [NRET*5-1:0]           rvfi_rs2_addr,
    input  logic [NRET*XLEN-1:0]        rvfi_rs1_rdata,
    input  logic [NRET*XLEN-1:0]        rvfi_rs2_rdata,
    input  logic [NRET*5-1:0]           rvfi_rd_addr,
    input  logic [NRET*XLEN-1:0]        rvfi_rd_wdata,
    output logic                        err,
    output logic [2:0]                  err_code,
    output logic [$clog2(NRET+0)+0:0]   err_chan,
    output logic [ORDER_W-1:0]          err_order,
    output logic [31:0]                 retired_cnt
);

    localparam int CW = $clog2(NRET) + 1;

    logic [4:0]         trk    [NTRACK];
    logic [4:0]         rs1_a  [NRET];
    logic [4:0]         rs2_a  [NRET];
    logic [4:0]         rd_a   [NRET];
    logic [XLEN-1:0]    rs1_d  [NRET];
    logic [XLEN-1:0]    rs2_d  [NRET];
    logic [XLEN-1:0]    rd_d   [NRET];
    logic [ORDER_W-1:0] ord    [NRET];

    logic [XLEN-1:0]    shadow_q [NTRACK];
    logic [XLEN-1:0]    shadow_d [NTRACK];
    logic [NTRACK-1:0]  written_q;
    logic [NTRACK-1:0]  written_d;
    logic [5:0]         hit;
    logic [2:0]         ch_code [NRET];

    logic               found;
    logic [2:0]         cap_code;
    logic [CW-1:0]      cap_chan;
    logic [ORDER_W-1:0] cap_order;
    logic [32:0]        cnt_sum;

`ifdef RISCV_FORMAL_REGCHK_ORDER_EN
    logic [ORDER_W-1:0] exp_q;
    logic [ORDER_W-1:0] exp_d;
`endif

    for (genvar t = 0; t < NTRACK; t++) begin : g_trk
        assign trk[t] = track_idx[t*5 +: 5];
    end

    for (genvar c = 0; c < NRET; c++) begin : g_chan
        assign rs1_a[c] = rvfi_rs1_addr[c*5 +: 5];
        assign rs2_a[c] = rvfi_rs2_addr[c*5 +: 5];
        assign rd_a[c]  = rvfi_rd_addr[c*5 +: 5];
        assign rs1_d[c] = rvfi_rs1_rdata[c*XLEN +: XLEN];
        assign rs2_d[c] = rvfi_rs2_rdata[c*XLEN +: XLEN];
        assign rd_d[c]  = rvfi_rd_wdata[c*XLEN +: XLEN];
        assign ord[c]   = rvfi_order[c*ORDER_W +: ORDER_W];
    end

    // Lowest raised code wins within one channel (bit i means code i+1).
    function automatic logic [2:0] low_code(input logic [5:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (m[i]) r = 3'(i + 1);
        end
        return r;
    endfunction

    // Walk channels in order; later channels see earlier same-cycle writes.
    always_comb begin
        shadow_d  = shadow_q;
        written_d = written_q;
        hit       = '0;
`ifdef RISCV_FORMAL_REGCHK_ORDER_EN
        exp_d     = exp_q;
`endif
        for (int c = 0; c < NRET; c++) begin
            ch_code[c] = 3'd0;
        end
        for (int c = 0; c < NRET; c++) begin
            hit = '0;
            if (rvfi_valid[c]) begin
                for (int t = 0; t < NTRACK; t++) begin
                    if ((written_d[t] || trk[t] == 5'd0) &&
                        rs1_a[c] == trk[t] && rs1_d[c] != shadow_d[t])
                        hit[0] = 1'b1;
                    if ((written_d[t] || trk[t] == 5'd0) &&
                        rs2_a[c] == trk[t] && rs2_d[c] != shadow_d[t])
                        hit[1] = 1'b1;
                end
                if (rd_a[c] == 5'd0 && rd_d[c] != '0)
                    hit[2] = 1'b1;
                if ((rs1_a[c] == 5'd0 && rs1_d[c] != '0) ||
                    (rs2_a[c] == 5'd0 && rs2_d[c] != '0))
                    hit[3] = 1'b1;
`ifdef RISCV_FORMAL_REGCHK_ORDER_EN
                if (ord[c] != exp_d)
                    hit[4] = 1'b1;
                exp_d = ord[c] + ORDER_W'(1);
`endif
                if (rvfi_trap[c] && rd_a[c] != 5'd0)
                    hit[5] = 1'b1;
                if (!rvfi_trap[c] && rd_a[c] != 5'd0) begin
                    for (int t = 0; t < NTRACK; t++) begin
                        if (rd_a[c] == trk[t]) begin
                            shadow_d[t]  = rd_d[c];
                            written_d[t] = 1'b1;
                        end
                    end
                end
            end
            ch_code[c] = low_code(hit);
        end
    end

    // Pick the lowest-index channel that raised anything this cycle.
    always_comb begin
        found     = 1'b0;
        cap_code  = 3'd0;
        cap_chan  = '0;
        cap_order = '0;
        for (int c = 0; c < NRET; c++) begin
            if (!found && ch_code[c] != 3'd0) begin
                found     = 1'b1;
                cap_code  = ch_code[c];
                cap_chan  = CW'(c);
                cap_order = ord[c];
            end
        end
        cnt_sum = {1'b0, retired_cnt} + 33'($countones(rvfi_valid));
    end

    // Shadow values and written flags follow the end of the channel chain.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int t = 0; t < NTRACK; t++) begin
                shadow_q[t] <= '0;
            end
            written_q <= {NTRACK{ZERO_INIT != 0}};
        end else begin
            for (int t = 0; t < NTRACK; t++) begin
                shadow_q[t] <= shadow_d[t];
            end
            written_q <= written_d;
        end
    end

`ifdef RISCV_FORMAL_REGCHK_ORDER_EN
    // Expected order resyncs past a gap so one gap reports once.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) exp_q <= '0;
        else         exp_q <= exp_d;
    end
`endif

    // First error is latched and held until reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err       <= 1'b0;
            err_code  <= 3'd0;
            err_chan  <= '0;
            err_order <= '0;
        end else if (!err && found) begin
            err       <= 1'b1;
            err_code  <= cap_code;
            err_chan  <= cap_chan;
            err_order <= cap_order;
        end
    end

    // Saturating retirement counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)         retired_cnt <= '0;
        else if (cnt_sum[32]) retired_cnt <= '1;
        else                 retired_cnt <= cnt_sum[31:0];
    end

endmodule

// File: tb/tb_rvfi_regfile_shadow_check.sv
// Bench for rvfi_regfile_shadow_check: two instances (2-channel cold start,
// 1-channel zero-init) against an architectural register-file model.
module tb_rvfi_regfile_shadow_check;

    logic clk = 1'b0;
    logic resetn = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Per-instance (k) per-channel (c) retirement fields.
    logic        v   [2][2];
    logic        tr  [2][2];
    logic [4:0]  a1  [2][2];
    logic [4:0]  a2  [2][2];
    logic [4:0]  ad  [2][2];
    logic [31:0] d1  [2][2];
    logic [31:0] d2  [2][2];
    logic [31:0] wd  [2][2];
    logic [63:0] ord [2][2];

    // Instance A: NRET=2, tracks x5, x3, x3, cold start.
    logic        a_err;
    logic [2:0]  a_code;
    logic [1:0]  a_chan;
    logic [63:0] a_order;
    logic [31:0] a_cnt;
    // Instance B: NRET=1, tracks x5 and x0, zero-init.
    logic        b_err;
    logic [2:0]  b_code;
    logic [0:0]  b_chan;
    logic [63:0] b_order;
    logic [31:0] b_cnt;

    rvfi_regfile_shadow_check #(
        .XLEN(32), .NRET(2), .NTRACK(3), .ORDER_W(64), .ZERO_INIT(0)
    ) u_a (
        .clk            (clk),
        .resetn         (resetn),
        .track_idx      ({5'd3, 5'd3, 5'd5}),
        .rvfi_valid     ({v[0][1], v[0][0]}),
        .rvfi_order     ({ord[0][1], ord[0][0]}),
        .rvfi_trap      ({tr[0][1], tr[0][0]}),
        .rvfi_rs1_addr  ({a1[0][1], a1[0][0]}),
        .rvfi_rs2_addr  ({a2[0][1], a2[0][0]}),
        .rvfi_rs1_rdata ({d1[0][1], d1[0][0]}),
        .rvfi_rs2_rdata ({d2[0][1], d2[0][0]}),
        .rvfi_rd_addr   ({ad[0][1], ad[0][0]}),
        .rvfi_rd_wdata  ({wd[0][1], wd[0][0]}),
        .err            (a_err),
        .err_code       (a_code),
        .err_chan       (a_chan),
        .err_order      (a_order),
        .retired_cnt    (a_cnt)
    );

    rvfi_regfile_shadow_check #(
        .XLEN(32), .NRET(1), .NTRACK(2), .ORDER_W(64), .ZERO_INIT(1)
    ) u_b (
        .clk            (clk),
        .resetn         (resetn),
        .track_idx      ({5'd0, 5'd5}),
        .rvfi_valid     (v[1][0]),
        .rvfi_order     (ord[1][0]),
        .rvfi_trap      (tr[1][0]),
        .rvfi_rs1_addr  (a1[1][0]),
        .rvfi_rs2_addr  (a2[1][0]),
        .rvfi_rs1_rdata (d1[1][0]),
        .rvfi_rs2_rdata (d2[1][0]),
        .rvfi_rd_addr   (ad[1][0]),
        .rvfi_rd_wdata  (wd[1][0]),
        .err            (b_err),
        .err_code       (b_code),
        .err_chan       (b_chan),
        .err_order      (b_order),
        .retired_cnt    (b_cnt)
    );

    // Architectural model: last value written to every register.
    logic [31:0] mval   [2][32];
    bit          mwr    [2][32];
    bit          merr   [2];
    logic [2:0]  mcode  [2];
    logic [63:0] mchan  [2];
    logic [63:0] morder [2];
    logic [63:0] mcnt   [2];
    logic [63:0] mexp   [2];
    logic [63:0] nord   [2];

    function automatic bit tracked(int k, logic [4:0] r);
        if (k == 0) return (r == 5'd5 || r == 5'd3);
        return (r == 5'd5 || r == 5'd0);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 32; r++) begin
                mval[k][r] = '0;
                mwr[k][r]  = (k == 1) || (r == 0);
            end
            merr[k] = 0; mcode[k] = 0; mchan[k] = 0;
            morder[k] = 0; mcnt[k] = 0; mexp[k] = 0; nord[k] = 0;
        end
    endtask

    task automatic model_chan(int k, int c);
        logic [2:0] code;
        if (!v[k][c]) return;
        if (mcnt[k] < 64'hFFFF_FFFF) mcnt[k]++;
        code = 0;
        if (tr[k][c] && ad[k][c] != 0) code = 6;
`ifdef RISCV_FORMAL_REGCHK_ORDER_EN
        if (ord[k][c] != mexp[k]) code = 5;
        mexp[k] = ord[k][c] + 1;
`endif
        if ((a1[k][c] == 0 && d1[k][c] != 0) ||
            (a2[k][c] == 0 && d2[k][c] != 0)) code = 4;
        if (ad[k][c] == 0 && wd[k][c] != 0) code = 3;
        if (tracked(k, a2[k][c]) && mwr[k][a2[k][c]] &&
            d2[k][c] != mval[k][a2[k][c]]) code = 2;
        if (tracked(k, a1[k][c]) && mwr[k][a1[k][c]] &&
            d1[k][c] != mval[k][a1[k][c]]) code = 1;
        if (!merr[k] && code != 0) begin
            merr[k] = 1; mcode[k] = code;
            mchan[k] = 64'(c); morder[k] = ord[k][c];
        end
        if (!tr[k][c] && ad[k][c] != 0) begin
            mval[k][ad[k][c]] = wd[k][c];
            mwr[k][ad[k][c]]  = 1;
        end
    endtask

    task automatic chk(string tag, logic [63:0] o, logic [63:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic check_all();
        chk("a_err",   64'(a_err),   64'(merr[0]));
        chk("a_code",  64'(a_code),  64'(mcode[0]));
        chk("a_chan",  64'(a_chan),  mchan[0]);
        chk("a_order", a_order,      morder[0]);
        chk("a_cnt",   64'(a_cnt),   mcnt[0]);
        chk("b_err",   64'(b_err),   64'(merr[1]));
        chk("b_code",  64'(b_code),  64'(mcode[1]));
        chk("b_chan",  64'(b_chan),  mchan[1]);
        chk("b_order", b_order,      morder[1]);
        chk("b_cnt",   64'(b_cnt),   mcnt[1]);
    endtask

    task automatic clr();
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < 2; c++) begin
                v[k][c] = 0; tr[k][c] = 0;
                a1[k][c] = 0; a2[k][c] = 0; ad[k][c] = 0;
                d1[k][c] = 0; d2[k][c] = 0; wd[k][c] = 0;
                ord[k][c] = 0;
            end
        end
    endtask

    task automatic ret(int k, int c, logic t,
                       logic [4:0] r1, logic [31:0] x1,
                       logic [4:0] r2, logic [31:0] x2,
                       logic [4:0] rd, logic [31:0] w);
        v[k][c] = 1; tr[k][c] = t;
        a1[k][c] = r1; d1[k][c] = x1;
        a2[k][c] = r2; d2[k][c] = x2;
        ad[k][c] = rd; wd[k][c] = w;
        ord[k][c] = nord[k];
        nord[k]++;
        model_chan(k, c);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        check_all();
        clr();
    endtask

    task automatic rst();
        resetn = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        resetn = 1'b1;
    endtask

    function automatic logic [4:0] pick();
        case ($urandom_range(4, 0))
            0:       return 5'd0;
            1:       return 5'd3;
            2:       return 5'd5;
            3:       return 5'd1;
            default: return 5'd7;
        endcase
    endfunction

    function automatic logic [31:0] good(int k, logic [4:0] r);
        logic [31:0] x;
        if (r == 0) x = 0;
        else if (tracked(k, r) && mwr[k][r]) x = mval[k][r];
        else x = $urandom;
        if ($urandom_range(39, 0) == 0)
            x = x ^ (32'h1 << $urandom_range(31, 0));
        return x;
    endfunction

    task automatic rnd_chan(int k, int c);
        logic [4:0]  r1, r2, rd;
        logic [31:0] x1, x2, w;
        logic        t;
        if ($urandom_range(3, 0) == 0) return;
        t  = ($urandom_range(31, 0) == 0);
        r1 = pick(); x1 = good(k, r1);
        r2 = pick(); x2 = good(k, r2);
        rd = pick(); w = $urandom;
        if (rd == 0) w = ($urandom_range(39, 0) == 0) ? 32'h5 : 32'h0;
        ret(k, c, t, r1, x1, r2, x2, rd, w);
    endtask

    initial begin
        clr();
        model_reset();
        #2;
        rst();

        // Write then consistent read of x5; same-cycle forward of x3.
        ret(0, 0, 0, 0, 0, 0, 0, 5, 32'hDEAD_BEEF);
        ret(1, 0, 0, 5, 32'h7, 0, 0, 0, 0);
        cyc();
        ret(0, 0, 0, 5, 32'hDEAD_BEEF, 0, 0, 0, 0);
        cyc();
        ret(0, 0, 0, 0, 0, 0, 0, 3, 32'h1234);
        ret(0, 1, 0, 3, 32'h1234, 0, 0, 0, 0);
        cyc();
        // rs2 mismatch captured, later mismatch ignored.
        ret(0, 0, 0, 0, 0, 5, 32'h1, 0, 0);
        cyc();
        ret(0, 0, 0, 5, 32'h9, 0, 0, 0, 32'h5);
        cyc();

        // Forwarded value mismatching on channel 1.
        rst();
        ret(0, 0, 0, 0, 0, 0, 0, 3, 32'h1234);
        ret(0, 1, 0, 3, 32'h0, 0, 0, 0, 0);
        cyc();

        // Unwritten read is free after reset; then x0 write.
        rst();
        ret(0, 0, 0, 5, 32'h77, 0, 0, 0, 0);
        cyc();
        ret(0, 0, 0, 0, 0, 0, 0, 0, 32'h5);
        cyc();

        // Trapped write, then read of the old value.
        rst();
        ret(0, 0, 0, 0, 0, 0, 0, 5, 32'h11);
        cyc();
        ret(0, 0, 1, 0, 0, 0, 0, 5, 32'h9);
        cyc();
        ret(0, 0, 0, 5, 32'h11, 0, 0, 0, 0);
        cyc();

        // Order sequence 0,1,3,4.
        rst();
        ret(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        ret(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        nord[0] = 3;
        ret(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        ret(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc();

        // Several codes in one cycle; tracked-x0 read on B.
        rst();
        ret(0, 0, 0, 0, 32'h5, 0, 0, 0, 32'h3);
        ret(0, 1, 0, 3, 32'h1, 0, 0, 5, 32'h2);
        ret(1, 0, 0, 0, 32'h4, 0, 0, 0, 0);
        cyc();

        // Randomized epochs, each from a fresh reset.
        for (int e = 0; e < 8; e++) begin
            rst();
            for (int i = 0; i < 40; i++) begin
                rnd_chan(0, 0);
                rnd_chan(0, 1);
                rnd_chan(1, 0);
                cyc();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
